alu_op_sequencer: RTL and testbench

//  Initiator that drives the 8-bit accumulator ALU. Accepts one command at a time (op, source, operands)

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_op_decode.sv | 52 +++++
 rtl/alu_op_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU op sequencer: command codes, one-hot ALU selects
// and the sequencer state type.
package alu_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;
    localparam logic [2:0] OP_MULT = 3'd6;

    localparam logic [1:0] SRC_PERSIST = 2'd0;
    localparam logic [1:0] SRC_LOAD    = 2'd1;
    localparam logic [1:0] SRC_RESET   = 2'd2;

    localparam logic [2:0] IN_SEL_PERSIST = 3'b100;
    localparam logic [2:0] IN_SEL_LOAD    = 3'b010;
    localparam logic [2:0] IN_SEL_RESET   = 3'b001;

    localparam logic [6:0] OUT_SEL_NONE = 7'b0000000;
    localparam logic [6:0] OUT_SEL_AND  = 7'b1000000;
    localparam logic [6:0] OUT_SEL_OR   = 7'b0100000;
    localparam logic [6:0] OUT_SEL_NOT  = 7'b0010000;
    localparam logic [6:0] OUT_SEL_XOR  = 7'b0001000;
    localparam logic [6:0] OUT_SEL_ADD  = 7'b0000100;
    localparam logic [6:0] OUT_SEL_SUB  = 7'b0000010;
    localparam logic [6:0] OUT_SEL_MULT = 7'b0000001;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ERR   = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational command decoder: op/source codes to one-hot ALU selects plus
// a legality flag covering both fields.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [2:0] cmd_op,
    input  logic [1:0] cmd_src,
    output logic [6:0] out_sel,
    output logic [2:0] in_sel,
    output logic       legal
);

    logic op_ok_s;
    logic src_ok_s;

    // Op code to one-hot ALU output select
    always_comb begin
        out_sel = OUT_SEL_NONE;
        op_ok_s = 1'b1;
        case (cmd_op)
            OP_AND:  out_sel = OUT_SEL_AND;
            OP_OR:   out_sel = OUT_SEL_OR;
            OP_NOT:  out_sel = OUT_SEL_NOT;
            OP_XOR:  out_sel = OUT_SEL_XOR;
            OP_ADD:  out_sel = OUT_SEL_ADD;
            OP_SUB:  out_sel = OUT_SEL_SUB;
            OP_MULT: out_sel = OUT_SEL_MULT;
            default: begin
                out_sel = OUT_SEL_NONE;
                op_ok_s = 1'b0;
            end
        endcase
    end

    // Source code to one-hot accumulator input select
    always_comb begin
        in_sel   = IN_SEL_PERSIST;
        src_ok_s = 1'b1;
        case (cmd_src)
            SRC_PERSIST: in_sel = IN_SEL_PERSIST;
            SRC_LOAD:    in_sel = IN_SEL_LOAD;
            SRC_RESET:   in_sel = IN_SEL_RESET;
            default: begin
                in_sel   = IN_SEL_PERSIST;
                src_ok_s = 1'b0;
            end
        endcase
    end

    assign legal = op_ok_s & src_ok_s;

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one command at a time to the accumulator ALU, waits its latency and
// returns the captured result/error over a valid/ready response port.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [1:0]        cmd_src,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic [2:0]        alu_in_sel,
    output logic [DATA_W-1:0] alu_num1,
    output logic [DATA_W-1:0] alu_num2,
    output logic [6:0]        alu_out_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_ovf,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [CNT_W-1:0]  err_count
);

    localparam int                WCNT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(ALU_LAT - 1);
    localparam logic [WCNT_W-1:0] WAIT_ONE  = WCNT_W'(1'b1);
    localparam logic [WCNT_W-1:0] WAIT_ZERO = WCNT_W'(1'b0);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    state_e            state_r, state_nxt_s;
    logic [WCNT_W-1:0] wait_cnt_r, wait_cnt_nxt_s;
    logic [2:0]        in_sel_r, in_sel_nxt_s;
    logic [6:0]        out_sel_r, out_sel_nxt_s;
    logic [DATA_W-1:0] num1_r, num1_nxt_s, num2_r, num2_nxt_s;
    logic              rsp_valid_r, rsp_valid_nxt_s;
    logic [DATA_W-1:0] rsp_data_r, rsp_data_nxt_s;
    logic              rsp_err_r, rsp_err_nxt_s;
    logic [CNT_W-1:0]  err_count_r, err_count_nxt_s;
    logic              cmd_ready_r, busy_r;

    logic [6:0]        dec_out_sel_s;
    logic [2:0]        dec_in_sel_s;
    logic              dec_legal_s;

    alu_op_decode u_decode (
        .cmd_op  (cmd_op),
        .cmd_src (cmd_src),
        .out_sel (dec_out_sel_s),
        .in_sel  (dec_in_sel_s),
        .legal   (dec_legal_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state plus next value of every registered output; ALU drive is
    // computed one cycle ahead so it is valid throughout the target state.
    always_comb begin
        state_nxt_s     = state_r;
        wait_cnt_nxt_s  = wait_cnt_r;
        in_sel_nxt_s    = in_sel_r;
        out_sel_nxt_s   = out_sel_r;
        num1_nxt_s      = num1_r;
        num2_nxt_s      = num2_r;
        rsp_valid_nxt_s = rsp_valid_r;
        rsp_data_nxt_s  = rsp_data_r;
        rsp_err_nxt_s   = rsp_err_r;
        err_count_nxt_s = err_count_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && dec_legal_s) begin
                    state_nxt_s    = ST_ISSUE;
                    in_sel_nxt_s   = dec_in_sel_s;
                    out_sel_nxt_s  = dec_out_sel_s;
                    num1_nxt_s     = cmd_a;
                    num2_nxt_s     = cmd_b;
                    wait_cnt_nxt_s = WAIT_LOAD;
                end else if (cmd_valid) begin
                    state_nxt_s     = ST_RESP;
                    rsp_valid_nxt_s = 1'b1;
                    rsp_data_nxt_s  = DATA_ZERO;
                    rsp_err_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nxt_s  = ST_WAIT;
                in_sel_nxt_s = IN_SEL_PERSIST;
            end
            ST_WAIT: begin
                if (wait_cnt_r == WAIT_ZERO) begin
                    rsp_data_nxt_s = alu_result;
                    rsp_err_nxt_s  = alu_ovf;
                    if (alu_ovf) begin
                        state_nxt_s  = ST_ERR;
                        in_sel_nxt_s = IN_SEL_RESET;
                    end else begin
                        state_nxt_s     = ST_RESP;
                        rsp_valid_nxt_s = 1'b1;
                        out_sel_nxt_s   = OUT_SEL_NONE;
                        num1_nxt_s      = DATA_ZERO;
                        num2_nxt_s      = DATA_ZERO;
                    end
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r - WAIT_ONE;
                end
            end
            ST_ERR: begin
                state_nxt_s     = ST_RESP;
                rsp_valid_nxt_s = 1'b1;
                in_sel_nxt_s    = IN_SEL_PERSIST;
                out_sel_nxt_s   = OUT_SEL_NONE;
                num1_nxt_s      = DATA_ZERO;
                num2_nxt_s      = DATA_ZERO;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s     = ST_IDLE;
                    rsp_valid_nxt_s = 1'b0;
                    if (rsp_err_r && (err_count_r != CNT_MAX)) begin
                        err_count_nxt_s = err_count_r + CNT_ONE;
                    end else begin
                        err_count_nxt_s = err_count_r;
                    end
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                rsp_valid_nxt_s = 1'b0;
                in_sel_nxt_s    = IN_SEL_PERSIST;
                out_sel_nxt_s   = OUT_SEL_NONE;
                num1_nxt_s      = DATA_ZERO;
                num2_nxt_s      = DATA_ZERO;
            end
        endcase
    end

    // Output, wait-counter and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r  <= WAIT_ZERO;
            in_sel_r    <= IN_SEL_PERSIST;
            out_sel_r   <= OUT_SEL_NONE;
            num1_r      <= DATA_ZERO;
            num2_r      <= DATA_ZERO;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= DATA_ZERO;
            rsp_err_r   <= 1'b0;
            err_count_r <= {CNT_W{1'b0}};
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            wait_cnt_r  <= wait_cnt_nxt_s;
            in_sel_r    <= in_sel_nxt_s;
            out_sel_r   <= out_sel_nxt_s;
            num1_r      <= num1_nxt_s;
            num2_r      <= num2_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_data_r  <= rsp_data_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
            err_count_r <= err_count_nxt_s;
            cmd_ready_r <= (state_nxt_s == ST_IDLE);
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign busy        = busy_r;
    assign alu_in_sel  = in_sel_r;
    assign alu_out_sel = out_sel_r;
    assign alu_num1    = num1_r;
    assign alu_num2    = num2_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_data    = rsp_data_r;
    assign rsp_err     = rsp_err_r;
    assign err_count   = err_count_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: behavioural accumulator ALU with
// configurable latency, plus an arithmetic reference model of each response.
module tb_alu_op_sequencer;

    localparam int DW  = 8;
    localparam int LAT = 3;
    localparam int CW  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'd0;
    logic [1:0]    cmd_src = 2'd0;
    logic [DW-1:0] cmd_a = '0;
    logic [DW-1:0] cmd_b = '0;
    logic [2:0]    alu_in_sel;
    logic [DW-1:0] alu_num1, alu_num2;
    logic [6:0]    alu_out_sel;
    logic [DW-1:0] alu_result;
    logic          alu_ovf;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          busy;
    logic [CW-1:0] err_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DATA_W(DW), .ALU_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_src(cmd_src),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_in_sel(alu_in_sel), .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_out_sel(alu_out_sel),
        .alu_result(alu_result), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .err_count(err_count)
    );

    // ---------------- behavioural ALU: operand register then LAT-1 extra stages
    logic [DW-1:0] acc_m;
    logic [DW-1:0] res_p [LAT];
    logic          ovf_p [LAT];

    function automatic logic [DW-1:0] alu_a(input logic [2:0] sel, input logic [DW-1:0] n1, input logic [DW-1:0] acc);
        if (sel == 3'b010) return n1;
        else if (sel == 3'b001) return '0;
        else return acc;
    endfunction

    function automatic logic [DW:0] alu_calc(input logic [6:0] sel, input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [2*DW-1:0] p;
        p = x * y;
        case (sel)
            7'b1000000: return {1'b0, x & y};
            7'b0100000: return {1'b0, x | y};
            7'b0010000: return {1'b0, ~x};
            7'b0001000: return {1'b0, x ^ y};
            7'b0000100: return {1'b0, x + y};
            7'b0000010: return {1'b0, x - y};
            7'b0000001: return {(p[2*DW-1:DW] != '0), p[DW-1:0]};
            default:    return '0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_m <= '0;
            for (int i = 0; i < LAT; i++) begin
                res_p[i] <= '0;
                ovf_p[i] <= 1'b0;
            end
        end else begin
            acc_m    <= alu_a(alu_in_sel, alu_num1, acc_m);
            res_p[0] <= alu_calc(alu_out_sel, alu_a(alu_in_sel, alu_num1, acc_m), alu_num2)[DW-1:0];
            ovf_p[0] <= alu_calc(alu_out_sel, alu_a(alu_in_sel, alu_num1, acc_m), alu_num2)[DW];
            for (int i = 1; i < LAT; i++) begin
                res_p[i] <= res_p[i-1];
                ovf_p[i] <= ovf_p[i-1];
            end
        end
    end

    assign alu_result = res_p[LAT-1];
    assign alu_ovf    = ovf_p[LAT-1];

    // ---------------- reference model of a whole command/response
    int            acc_ref = 0;
    int            err_ref = 0;
    logic [DW-1:0] exp_data, exp_n1, exp_n2;
    logic          exp_err;
    int            exp_lat, exp_errcyc;
    logic [2:0]    exp_in;
    logic [6:0]    exp_out;

    // Expected latency counts edges after the accept edge until rsp_valid is seen.
    task automatic ref_cmd(input logic [2:0] op, input logic [1:0] src, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int x, full;
        if (op == 3'd7 || src == 2'd3) begin
            exp_data = '0; exp_err = 1'b1; exp_lat = 0; exp_errcyc = 0;
            exp_in = 3'b100; exp_out = 7'd0; exp_n1 = '0; exp_n2 = '0;
        end else begin
            x = (src == 2'd1) ? int'(a) : (src == 2'd2) ? 0 : acc_ref;
            case (op)
                3'd0: full = x & int'(b);
                3'd1: full = x | int'(b);
                3'd2: full = ~x;
                3'd3: full = x ^ int'(b);
                3'd4: full = x + int'(b);
                3'd5: full = x - int'(b);
                default: full = x * int'(b);
            endcase
            exp_data   = full[DW-1:0];
            exp_err    = (op == 3'd6) && (full > (1 << DW) - 1);
            exp_lat    = exp_err ? LAT + 2 : LAT + 1;
            exp_errcyc = exp_err ? 1 : 0;
            exp_in     = 3'b100 >> src;
            exp_out    = 7'b1000000 >> op;
            exp_n1     = a;
            exp_n2     = b;
            acc_ref    = exp_err ? 0 : x;
        end
        if (exp_err && err_ref < (1 << CW) - 1) err_ref++;
    endtask

    // ---------------- stimulus helpers (capture only)
    int            obs_lat, obs_errcyc;
    logic [2:0]    obs_in;
    logic [6:0]    obs_out;
    logic [DW-1:0] obs_n1, obs_n2, obs_data;
    logic          obs_err, obs_stable, obs_ready_after, obs_valid_after, obs_busy_after;

    task automatic do_cmd(input logic [2:0] op, input logic [1:0] src, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) begin total++; bad++; $display("FAIL cmd_ready_timeout got=%b want=1", cmd_ready); end
        cmd_op = op; cmd_src = src; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        obs_in = alu_in_sel; obs_out = alu_out_sel; obs_n1 = alu_num1; obs_n2 = alu_num2;
        obs_lat = 0; obs_errcyc = 0;
        while (rsp_valid !== 1'b1 && obs_lat < 50) begin
            @(posedge clk); #1;
            obs_lat++;
            if (alu_in_sel === 3'b001) obs_errcyc++;
        end
        obs_data = rsp_data; obs_err = rsp_err;
        ref_cmd(op, src, a, b);
    endtask

    task automatic finish_rsp(input int hold);
        obs_stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_data !== obs_data || rsp_err !== obs_err || cmd_ready !== 1'b0 || busy !== 1'b1)
                obs_stable = 1'b0;
        end
        if (cmd_ready !== 1'b0) obs_stable = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        obs_ready_after = cmd_ready; obs_valid_after = rsp_valid; obs_busy_after = busy;
    endtask

    // ---------------- tests
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (alu_in_sel !== 3'b100) begin bad++; $display("FAIL reset_in_sel got=%b want=100", alu_in_sel); end
        total++; if (alu_out_sel !== 7'd0) begin bad++; $display("FAIL reset_out_sel got=%b want=0", alu_out_sel); end
        total++; if (err_count !== '0) begin bad++; $display("FAIL reset_err_count got=%0d want=0", err_count); end
        total++; if (busy !== 1'b0 || rsp_data !== '0 || rsp_err !== 1'b0) begin bad++; $display("FAIL reset_misc got=%b/%h/%b want=0/00/0", busy, rsp_data, rsp_err); end
        rst_n = 1'b1; acc_ref = 0; err_ref = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_add_load();
        do_cmd(3'd4, 2'd1, 8'h12, 8'h05);
        total++; if (obs_in !== exp_in) begin bad++; $display("FAIL add_in_sel got=%b want=%b", obs_in, exp_in); end
        total++; if (obs_out !== exp_out) begin bad++; $display("FAIL add_out_sel got=%b want=%b", obs_out, exp_out); end
        total++; if (obs_n1 !== exp_n1 || obs_n2 !== exp_n2) begin bad++; $display("FAIL add_operands got=%h,%h want=%h,%h", obs_n1, obs_n2, exp_n1, exp_n2); end
        total++; if (obs_lat !== exp_lat) begin bad++; $display("FAIL add_latency got=%0d want=%0d", obs_lat, exp_lat); end
        total++; if (obs_data !== exp_data || obs_err !== exp_err) begin bad++; $display("FAIL add_rsp got=%h/%b want=%h/%b", obs_data, obs_err, exp_data, exp_err); end
        finish_rsp(0);
        total++; if (obs_ready_after !== 1'b1) begin bad++; $display("FAIL add_ready_after got=%b want=1", obs_ready_after); end
    endtask

    task automatic test_mult_ovf();
        do_cmd(3'd6, 2'd1, 8'h20, 8'h10);
        total++; if (obs_lat !== exp_lat) begin bad++; $display("FAIL mult_latency got=%0d want=%0d", obs_lat, exp_lat); end
        total++; if (obs_errcyc !== exp_errcyc) begin bad++; $display("FAIL mult_err_cycles got=%0d want=%0d", obs_errcyc, exp_errcyc); end
        total++; if (obs_data !== exp_data || obs_err !== exp_err) begin bad++; $display("FAIL mult_rsp got=%h/%b want=%h/%b", obs_data, obs_err, exp_data, exp_err); end
        finish_rsp(0);
        total++; if (int'(err_count) !== err_ref) begin bad++; $display("FAIL mult_err_count got=%0d want=%0d", err_count, err_ref); end
    endtask

    task automatic test_backpressure();
        do_cmd(3'd3, 2'd0, 8'h00, 8'h5A);
        total++; if (obs_data !== exp_data || obs_err !== exp_err) begin bad++; $display("FAIL bp_rsp got=%h/%b want=%h/%b", obs_data, obs_err, exp_data, exp_err); end
        finish_rsp(10);
        total++; if (obs_stable !== 1'b1) begin bad++; $display("FAIL bp_stable got=%b want=1", obs_stable); end
        total++; if (obs_ready_after !== 1'b1 || obs_valid_after !== 1'b0 || obs_busy_after !== 1'b0) begin
            bad++; $display("FAIL bp_after got=%b%b%b want=100", obs_ready_after, obs_valid_after, obs_busy_after); end
    endtask

    task automatic test_illegal();
        do_cmd(3'd7, 2'd1, 8'h33, 8'h44);
        total++; if (obs_out !== 7'd0 || obs_lat !== exp_lat) begin bad++; $display("FAIL illegal_op got=%b/%0d want=0/%0d", obs_out, obs_lat, exp_lat); end
        total++; if (obs_data !== exp_data || obs_err !== exp_err) begin bad++; $display("FAIL illegal_op_rsp got=%h/%b want=%h/%b", obs_data, obs_err, exp_data, exp_err); end
        finish_rsp(0);
        do_cmd(3'd1, 2'd3, 8'h33, 8'h44);
        total++; if (obs_out !== 7'd0 || obs_lat !== exp_lat) begin bad++; $display("FAIL illegal_src got=%b/%0d want=0/%0d", obs_out, obs_lat, exp_lat); end
        total++; if (obs_data !== exp_data || obs_err !== exp_err) begin bad++; $display("FAIL illegal_src_rsp got=%h/%b want=%h/%b", obs_data, obs_err, exp_data, exp_err); end
        finish_rsp(0);
        total++; if (int'(err_count) !== err_ref) begin bad++; $display("FAIL illegal_err_count got=%0d want=%0d", err_count, err_ref); end
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [1:0] src;
        for (int k = 0; k < 60; k++) begin
            op = 3'($urandom_range(0, 7));
            src = 2'($urandom_range(0, 3));
            do_cmd(op, src, 8'($urandom), 8'($urandom));
            total++; if (obs_lat !== exp_lat || obs_errcyc !== exp_errcyc) begin bad++; $display("FAIL rnd_timing k=%0d got=%0d/%0d want=%0d/%0d", k, obs_lat, obs_errcyc, exp_lat, exp_errcyc); end
            total++; if (obs_data !== exp_data || obs_err !== exp_err) begin bad++; $display("FAIL rnd_rsp k=%0d got=%h/%b want=%h/%b", k, obs_data, obs_err, exp_data, exp_err); end
            total++; if (obs_in !== exp_in || obs_out !== exp_out) begin bad++; $display("FAIL rnd_issue k=%0d got=%b/%b want=%b/%b", k, obs_in, obs_out, exp_in, exp_out); end
            finish_rsp($urandom_range(0, 2));
            total++; if (obs_stable !== 1'b1 || int'(err_count) !== err_ref) begin bad++; $display("FAIL rnd_after k=%0d got=%b/%0d want=1/%0d", k, obs_stable, err_count, err_ref); end
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 260; k++) begin
            do_cmd(3'd7, 2'd0, 8'h00, 8'h00);
            finish_rsp(0);
        end
        total++; if (int'(err_count) !== err_ref || err_count !== 8'hFF) begin bad++; $display("FAIL sat_err_count got=%0d want=%0d", err_count, err_ref); end
    endtask

    task automatic test_reset_mid_wait();
        logic seen;
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        cmd_op = 3'd4; cmd_src = 2'd1; cmd_a = 8'h01; cmd_b = 8'h02; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midwait_busy_before got=%b want=1", busy); end
        rst_n = 1'b0;
        #1;
        total++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL midwait_ctrl got=%b%b%b want=100", cmd_ready, busy, rsp_valid); end
        total++; if (alu_in_sel !== 3'b100 || alu_out_sel !== 7'd0 || alu_num1 !== '0 || alu_num2 !== '0) begin
            bad++; $display("FAIL midwait_alu got=%b/%b/%h/%h want=100/0/00/00", alu_in_sel, alu_out_sel, alu_num1, alu_num2); end
        total++; if (err_count !== '0) begin bad++; $display("FAIL midwait_err_count got=%0d want=0", err_count); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; acc_ref = 0; err_ref = 0;
        seen = 1'b0;
        repeat (12) begin @(posedge clk); #1; if (rsp_valid !== 1'b0) seen = 1'b1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL midwait_no_rsp got=%b want=0", seen); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add_load();
        test_mult_ovf();
        test_backpressure();
        test_illegal();
        test_random();
        test_saturate();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
